wb_retire: RTL

Parametrised writeback/retire stage between the Memory stage and the Decode-stage register file. Accepts completed instructions over a valid/ready handshake and extracts and extends load data. Buffers pending register-file writes in a small in-order queue, drained under a register-file grant. Also provides a bypass lookup into pending writes and a retired-instruction counter.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_queue.sv | 60 ++++++
 rtl/wb_retire.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/retire stage: RV opcodes, load funct3
// codes and the register-file write-enable rule.
package wb_pkg;

  localparam int RD_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Stores and branches never write a register; x0 writes are discarded.
  function automatic logic rf_write_en(input logic [6:0] opcode,
                                       input logic [RD_W-1:0] rd);
    return !(opcode == OP_BRANCH || opcode == OP_STORE) && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_queue.sv
// In-order retire FIFO. Entries are also presented oldest-first with a valid
// mask so the bypass search can pick the youngest match.
module wb_queue
  import wb_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic [W-1:0] ent_age [DEPTH],
  output logic [DEPTH-1:0] vld_age
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  logic [W-1:0] mem [DEPTH];
  logic         push_en;
  logic         pop_en;

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_age[k] = mem[rd_ptr[AW-1:0] + AW'(k)];
      vld_age[k] = ((AW+1)'(k) < count);
    end
  end

endmodule

// File: rtl/wb_retire.sv
// Writeback/retire stage: load extraction, in-order register-file write
// queue drained under grant, bypass lookup into pending writes, retire count.
module wb_retire
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  output logic                       o_rdy,
  input  logic [RD_W-1:0]            i_rd,
  input  logic [6:0]                 i_opcode,
  input  logic [2:0]                 i_funct3,
  input  logic [$clog2(XLEN/8)-1:0]  i_addr_lo,
  input  logic [XLEN-1:0]            i_alu_data,
  input  logic [XLEN-1:0]            i_mem_data,
  output logic                       o_rf_wr,
  output logic [RD_W-1:0]            o_rf_rd,
  output logic [XLEN-1:0]            o_rf_data,
  input  logic                       i_rf_gnt,
  input  logic [RD_W-1:0]            i_fwd_rs,
  output logic                       o_fwd_hit,
  output logic [XLEN-1:0]            o_fwd_data,
  output logic [CNT_W-1:0]           o_retire_cnt,
  output logic                       o_empty
);

  localparam int AL = $clog2(XLEN/8);
  localparam logic [AL-1:0] WORD_MASK = (XLEN == 64) ? AL'(4) : '0;

  typedef struct packed {
    logic            wr;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  // Handshake: a transfer happens on a rising edge where i_vld && o_rdy.
  // o_rdy depends only on occupancy (never on i_vld or a same-cycle pop).
  logic            q_full;
  logic            q_empty;
  logic [EW-1:0]   q_head;
  logic [EW-1:0]   q_ent [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic            accept;
  logic            pop;
  entry_t          new_e;
  entry_t          head_e;
  logic [XLEN-1:0] ld_data;
  logic [AL-1:0]   h_off;
  logic [AL-1:0]   w_off;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_w;

  assign o_rdy   = !q_full;
  assign accept  = i_vld && o_rdy;
  assign o_empty = q_empty;
  assign head_e  = entry_t'(q_head);

  // Lane select: halfwords drop bit 0, words keep only bit 2 on RV64.
  assign h_off = {i_addr_lo[AL-1:1], 1'b0};
  assign w_off = i_addr_lo & WORD_MASK;
  assign ld_b  = i_mem_data[{i_addr_lo, 3'b000} +: 8];
  assign ld_h  = i_mem_data[{h_off, 3'b000} +: 16];
  assign ld_w  = i_mem_data[{w_off, 3'b000} +: 32];

  always_comb begin
    ld_data = '0;
    case (i_funct3)
      F3_LB:   ld_data = XLEN'($signed(ld_b));
      F3_LH:   ld_data = XLEN'($signed(ld_h));
      F3_LW:   ld_data = XLEN'($signed(ld_w));
      F3_LBU:  ld_data = XLEN'(ld_b);
      F3_LHU:  ld_data = XLEN'(ld_h);
      F3_LWU:  ld_data = (XLEN == 64) ? XLEN'(ld_w) : '0;
      F3_LD:   ld_data = (XLEN == 64) ? i_mem_data : '0;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    new_e.wr   = rf_write_en(i_opcode, i_rd);
    new_e.rd   = i_rd;
    new_e.data = (i_opcode == OP_LOAD) ? ld_data : i_alu_data;
  end

  wb_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (new_e),
    .pop       (pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .ent_age   (q_ent),
    .vld_age   (q_vld)
  );

  // Non-writing entries leave without waiting for the register file.
  assign pop       = !q_empty && (!head_e.wr || i_rf_gnt);
  assign o_rf_wr   = !q_empty && head_e.wr;
  assign o_rf_rd   = q_empty ? '0 : head_e.rd;
  assign o_rf_data = q_empty ? '0 : head_e.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_retire_cnt <= '0;
    end else if (pop) begin
      o_retire_cnt <= o_retire_cnt + CNT_W'(1);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    entry_t e;
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      e = entry_t'(q_ent[k]);
      if (q_vld[k] && e.wr && (e.rd == i_fwd_rs) && (i_fwd_rs != '0)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = e.data;
      end
    end
  end

endmodule
